// File: rtl/dsp_op_sequencer_pkg.sv
// dsp_op_sequencer_pkg
// Shared definitions for the DSP48A1 operation sequencer: sequencer state
// encoding, the width of the latency/init counter and the widths of the
// slice operand and result buses.
package dsp_op_sequencer_pkg;

  localparam int CNT_W    = 4;
  localparam int OPND_W   = 18;
  localparam int WIDE_W   = 48;
  localparam int OPMODE_W = 8;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RUN,
    ST_CAPT,
    ST_DONE
  } state_t;

  // One complete command as presented to / held on the slice inputs.
  typedef struct packed {
    logic [OPND_W-1:0]   a;
    logic [OPND_W-1:0]   b;
    logic [OPND_W-1:0]   d;
    logic [WIDE_W-1:0]   c;
    logic [OPMODE_W-1:0] opmode;
    logic                carryin;
  } operands_t;

endpackage

// File: rtl/dsp_op_sequencer.sv
// dsp_op_sequencer
// Drives one DSP48A1 slice through a single operation at a time. After reset
// the slice is held in reset for INIT_CYCLES cycles. A command accepted in
// IDLE is launched onto the slice inputs, the slice clock enable is held high
// for exactly LATENCY edges, then the enable is dropped so the slice output
// holds while P/CARRYOUT are captured. The captured result is offered on a
// valid/ready interface; only after it is consumed is a new command taken.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_a, cmd_b, cmd_d        18-bit operands
//   cmd_c                      48-bit post-adder operand
//   cmd_opmode, cmd_carryin    slice OPMODE and carry-in
//   res_valid / res_ready      result handshake
//   res_p, res_carryout        captured slice result
//   dsp_a .. dsp_carryin       registered operands toward the slice
//   dsp_ce                     drives every CE* pin of the slice
//   dsp_rst                    active-high, drives every RST* pin of the slice
//   dsp_p, dsp_carryout        slice outputs
module dsp_op_sequencer
  import dsp_op_sequencer_pkg::*;
#(
  parameter int LATENCY     = 3,
  parameter int INIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OPND_W-1:0]   cmd_a,
  input  logic [OPND_W-1:0]   cmd_b,
  input  logic [OPND_W-1:0]   cmd_d,
  input  logic [WIDE_W-1:0]   cmd_c,
  input  logic [OPMODE_W-1:0] cmd_opmode,
  input  logic                cmd_carryin,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [WIDE_W-1:0]   res_p,
  output logic                res_carryout,
  output logic [OPND_W-1:0]   dsp_a,
  output logic [OPND_W-1:0]   dsp_b,
  output logic [OPND_W-1:0]   dsp_d,
  output logic [WIDE_W-1:0]   dsp_c,
  output logic [OPMODE_W-1:0] dsp_opmode,
  output logic                dsp_carryin,
  output logic                dsp_ce,
  output logic                dsp_rst,
  input  logic [WIDE_W-1:0]   dsp_p,
  input  logic                dsp_carryout
);

  localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_CYCLES);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept;
  logic             capture;
  logic             release_res;

  // Next-state logic. The same counter times the post-reset slice reset
  // window (INIT) and the pipeline flight time (RUN); in both cases the state
  // advances on the edge where the counter steps from 1 to 0.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    accept      = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state)
      ST_INIT: begin
        if (cnt <= CNT_W'(1)) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept     = 1'b1;
          cnt_next   = LAT_LOAD;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt <= CNT_W'(1)) begin
          cnt_next   = '0;
          state_next = ST_CAPT;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      ST_CAPT: begin
        capture    = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (res_valid && res_ready) begin
          release_res = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  // State register. Control outputs are registered from the next state so
  // they line up with the state they describe without any output decoding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      cnt       <= INIT_LOAD;
      cmd_ready <= 1'b0;
      dsp_ce    <= 1'b0;
      dsp_rst   <= 1'b1;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      cmd_ready <= (state_next == ST_IDLE);
      dsp_ce    <= (state_next == ST_RUN);
      dsp_rst   <= (state_next == ST_INIT);
    end
  end

  // Operand and result registers. Operands change only on acceptance so the
  // slice sees stable inputs for the whole flight; OPMODE is passed through
  // untouched, P-feedback modes included. The result is captured one edge
  // after the enable drops, when the slice output is known to be frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_a        <= '0;
      dsp_b        <= '0;
      dsp_d        <= '0;
      dsp_c        <= '0;
      dsp_opmode   <= '0;
      dsp_carryin  <= 1'b0;
      res_valid    <= 1'b0;
      res_p        <= '0;
      res_carryout <= 1'b0;
    end else begin
      if (accept) begin
        dsp_a       <= cmd_a;
        dsp_b       <= cmd_b;
        dsp_d       <= cmd_d;
        dsp_c       <= cmd_c;
        dsp_opmode  <= cmd_opmode;
        dsp_carryin <= cmd_carryin;
      end
      if (capture) begin
        res_p        <= dsp_p;
        res_carryout <= dsp_carryout;
        res_valid    <= 1'b1;
      end else if (release_res) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
